axil_cmd_master: RTL and testbench
==================================

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, AXI-Lite data width; only 32 is supported.
REQ-002 The module SHALL have parameter ADDR_W, default 32, AXI-Lite address width.
REQ-003 The module SHALL have port pcie_clk  in  1  single clock for all logic.
REQ-004 The module SHALL have port pcie_rst  in  1  reset, asynchronous assert, active-high.
REQ-005 The module SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-006 The module SHALL have ports cmd_write in 1 (1=write, 0=read), cmd_addr in ADDR_W, cmd_wdata in DATA_W, cmd_wstrb in DATA_W/8.
REQ-007 The module SHALL have ports rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-008 The module SHALL have ports rsp_write out 1, rsp_rdata out DATA_W, rsp_resp out 2, rsp_latency out 16 (cycles).
REQ-009 The module SHALL have AXI-Lite master ports m_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready, with standard directions and widths.

Function
REQ-010 The module SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-011 cmd_ready SHALL be 1 only in IDLE; acceptance is cmd_valid&&cmd_ready, capturing all cmd_* fields into registers.
REQ-012 On a write accept: state->WR_REQ; m_axi_awvalid and m_axi_wvalid SHALL both be 1 the next cycle, driving the captured addr, data and strb.
REQ-013 In WR_REQ, awvalid and wvalid SHALL each deassert independently the cycle after their own handshake, and SHALL NOT deassert before it.
REQ-014 When both AW and W have completed (same or different cycles): state->WR_RESP, bready=1, and only in WR_RESP.
REQ-015 On bvalid&&bready: capture bresp; rsp_write=1, rsp_rdata=0; state->RSP.
REQ-016 On a read accept: state->RD_REQ, arvalid=1 next cycle with the captured addr; hold until arready.
REQ-017 On the AR handshake: state->RD_RESP, rready=1, and only in RD_RESP.
REQ-018 On rvalid&&rready: capture rdata and rresp; rsp_write=0; state->RSP.
REQ-019 In RSP, rsp_valid SHALL be 1 and the rsp_* outputs SHALL be stable until rsp_ready; on the handshake, state->IDLE.
REQ-020 At most one transaction SHALL be outstanding; the next cmd is accepted no earlier than the cycle after the rsp handshake.
REQ-021 The latency counter SHALL clear on cmd accept and increment each cycle, saturating at 16'hFFFF, with no wrap.
REQ-022 rsp_latency SHALL equal the number of clock edges from the cmd handshake edge to the B/R handshake edge, saturated.
REQ-023 All AXI valid/ready outputs and rsp_valid SHALL be registered, with no combinational path from AXI inputs.
REQ-024 SLVERR/DECERR responses SHALL be passed through unmodified and SHALL NOT cause a retry.

Reset
REQ-025 While pcie_rst=1: state=IDLE; all m_axi valid/ready outputs=0; rsp_valid=0; rsp_rdata, rsp_resp, rsp_latency, rsp_write=0; addr and data outputs=0.
REQ-026 A reset asserted mid-transaction SHALL abandon the transaction immediately with no response issued; after release, cmd_ready=1 in the first cycle.

Verification
REQ-027 Write addr=0x4, data=0xDEADBEEF, strb=0xF; slave always ready, bvalid immediate, OKAY -> one AW and one W beat, rsp_write=1, rsp_resp=0, rsp_latency=2.
REQ-028 Read addr=0x8; arready delayed 3 cycles, rdata=0x12345678 one cycle after AR -> araddr held stable throughout, rsp_rdata=0x12345678, rsp_latency=5.
REQ-029 Write with wready 4 cycles before awready, then with awready 4 cycles before wready -> each valid drops individually after its own handshake, bready rises only after both.
REQ-030 Read answered with rresp=2'b10; rsp_ready held 0 for 5 cycles -> rsp_resp=2, rsp_valid and rsp_* stable for 5 cycles, cmd_ready=0 until the rsp handshake.
REQ-031 bvalid withheld for 70000 cycles -> rsp_latency=16'hFFFF.
REQ-032 pcie_rst pulsed while in WR_REQ -> awvalid/wvalid=0 asynchronously, no rsp_valid, and the next command completes normally.

Source files
------------

// File: rtl/axil_cmd_master_if.sv
// AXI-Lite master/slave signal bundle used between axil_cmd_master and its target.
// The master drives addresses, write data, all VALIDs on request channels and the response READYs.
interface axil_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Turns one cmd/rsp request at a time into a single AXI-Lite read or write,
// returning the response code, read data and the cmd-to-response latency in cycles.
module axil_cmd_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                pcie_clk,
  input  logic                pcie_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [15:0]         rsp_latency,
  axil_cmd_master_if.master   m_axi,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t              state, state_n;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [15:0]         lat_q, lat_inc;
  logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n, rsp_valid_n;
  logic                cmd_accept, b_done, r_done;

  // Every channel transfers on a clock edge where its VALID and READY are both high;
  // a VALID, once raised, is held with stable payload until that edge and never waits on READY.
  assign cmd_ready       = (state == IDLE);
  assign state_dbg       = state;
  assign m_axi.awaddr    = addr_q;
  assign m_axi.araddr    = addr_q;
  assign m_axi.wdata     = wdata_q;
  assign m_axi.wstrb     = wstrb_q;
  assign m_axi.awvalid   = awvalid_q;
  assign m_axi.wvalid    = wvalid_q;
  assign m_axi.bready    = bready_q;
  assign m_axi.arvalid   = arvalid_q;
  assign m_axi.rready    = rready_q;
  assign lat_inc         = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;

  always_comb begin
    state_n     = state;
    awvalid_n   = awvalid_q;
    wvalid_n    = wvalid_q;
    arvalid_n   = arvalid_q;
    bready_n    = 1'b0;
    rready_n    = 1'b0;
    rsp_valid_n = 1'b0;
    cmd_accept  = 1'b0;
    b_done      = 1'b0;
    r_done      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cmd_accept = 1'b1;
          if (cmd_write) begin
            state_n   = WR_REQ;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
          end else begin
            state_n   = RD_REQ;
            arvalid_n = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; B is only requested once both have gone.
        awvalid_n = awvalid_q && !m_axi.awready;
        wvalid_n  = wvalid_q && !m_axi.wready;
        if (!awvalid_n && !wvalid_n) begin
          state_n  = WR_RESP;
          bready_n = 1'b1;
        end
      end
      WR_RESP: begin
        bready_n = 1'b1;
        if (m_axi.bvalid && bready_q) begin
          b_done      = 1'b1;
          bready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RD_REQ: begin
        if (m_axi.arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_RESP;
        end
      end
      RD_RESP: begin
        rready_n = 1'b1;
        if (m_axi.rvalid && rready_q) begin
          r_done      = 1'b1;
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RSP: begin
        rsp_valid_n = 1'b1;
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      lat_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_latency <= '0;
    end else begin
      state     <= state_n;
      awvalid_q <= awvalid_n;
      wvalid_q  <= wvalid_n;
      bready_q  <= bready_n;
      arvalid_q <= arvalid_n;
      rready_q  <= rready_n;
      rsp_valid <= rsp_valid_n;
      if (cmd_accept) begin
        wr_q    <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        lat_q   <= '0;
      end else begin
        lat_q <= lat_inc;
      end
      // Latency counts the edge of the B/R handshake itself, hence lat_inc.
      if (b_done) begin
        rsp_write   <= wr_q;
        rsp_rdata   <= '0;
        rsp_resp    <= m_axi.bresp;
        rsp_latency <= lat_inc;
      end
      if (r_done) begin
        rsp_write   <= wr_q;
        rsp_rdata   <= m_axi.rdata;
        rsp_resp    <= m_axi.rresp;
        rsp_latency <= lat_inc;
      end
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a delay-programmable AXI-Lite slave, a table of commands with
// model-derived expectations kept in a queue, per-cycle channel rule checks and reset corner cases.
module tb_axil_cmd_master;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int EXP_W  = 51;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W/8-1:0] cmd_wstrb;
  logic                rsp_valid, rsp_ready, rsp_write;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [1:0]          rsp_resp;
  logic [15:0]         rsp_latency;
  logic [2:0]          state_dbg;

  axil_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axil_cmd_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .pcie_clk    (clk),
    .pcie_rst    (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_latency (rsp_latency),
    .m_axi       (axi.master),
    .state_dbg   (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave model: each ready rises after its valid has waited cfg_*_dly cycles;
  // B/R come cfg_b_dly/cfg_r_dly cycles after the request phase completes.
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        aw_got, w_got, b_pend, r_pend;
  logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;

  assign axi.awready = axi.awvalid && (aw_cnt >= cfg_aw_dly);
  assign axi.wready  = axi.wvalid && (w_cnt >= cfg_w_dly);
  assign axi.arready = axi.arvalid && (ar_cnt >= cfg_ar_dly);
  assign axi.bvalid  = b_pend && (b_cnt >= cfg_b_dly);
  assign axi.rvalid  = r_pend && (r_cnt >= cfg_r_dly);
  assign axi.bresp   = cfg_resp;
  assign axi.rresp   = cfg_resp;
  assign axi.rdata   = cfg_rdata;
  assign hs_aw = axi.awvalid && axi.awready;
  assign hs_w  = axi.wvalid && axi.wready;
  assign hs_b  = axi.bvalid && axi.bready;
  assign hs_ar = axi.arvalid && axi.arready;
  assign hs_r  = axi.rvalid && axi.rready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      if (axi.awvalid && !axi.awready) aw_cnt <= aw_cnt + 1;
      if (hs_aw) begin aw_cnt <= 0; aw_got <= 1'b1; end
      if (axi.wvalid && !axi.wready) w_cnt <= w_cnt + 1;
      if (hs_w) begin w_cnt <= 0; w_got <= 1'b1; end
      if ((aw_got || hs_aw) && (w_got || hs_w) && !b_pend) begin
        b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (b_pend) begin
        if (hs_b) b_pend <= 1'b0;
        else      b_cnt <= b_cnt + 1;
      end
      if (axi.arvalid && !axi.arready) ar_cnt <= ar_cnt + 1;
      if (hs_ar) begin ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= 0; end
      if (r_pend) begin
        if (hs_r) r_pend <= 1'b0;
        else      r_cnt <= r_cnt + 1;
      end
    end
  end

  // channel monitor, sampled mid-cycle: hold-until-handshake, drop-after-handshake, bready ordering
  int          aw_beats = 0, w_beats = 0, ar_beats = 0;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, aw_seen, w_seen;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  always @(negedge clk) begin
    if (rst) begin
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
      aw_seen <= 1'b0; w_seen <= 1'b0;
    end else begin
      if (p_awv && !p_awr) begin
        check("awvalid_hold", axi.awvalid, 1);
        check("awaddr_stable", axi.awaddr, p_awaddr);
      end
      if (p_awv && p_awr) check("awvalid_drop", axi.awvalid, 0);
      if (p_wv && !p_wr) begin
        check("wvalid_hold", axi.wvalid, 1);
        check("wdata_stable", axi.wdata, p_wdata);
      end
      if (p_wv && p_wr) check("wvalid_drop", axi.wvalid, 0);
      if (p_arv && !p_arr) begin
        check("arvalid_hold", axi.arvalid, 1);
        check("araddr_stable", axi.araddr, p_araddr);
      end
      if (p_arv && p_arr) check("arvalid_drop", axi.arvalid, 0);
      if (axi.bready) check("bready_after_aw_w", {aw_seen, w_seen}, 2'b11);
      if (hs_aw) begin aw_beats <= aw_beats + 1; aw_seen <= 1'b1; end
      if (hs_w)  begin w_beats <= w_beats + 1; w_seen <= 1'b1; end
      if (hs_ar) ar_beats <= ar_beats + 1;
      if (hs_b)  begin aw_seen <= 1'b0; w_seen <= 1'b0; end
      p_awv <= axi.awvalid; p_awr <= axi.awready; p_awaddr <= axi.awaddr;
      p_wv  <= axi.wvalid;  p_wr  <= axi.wready;  p_wdata  <= axi.wdata;
      p_arv <= axi.arvalid; p_arr <= axi.arready; p_araddr <= axi.araddr;
    end
  end

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          hold;
    logic [15:0] exp_lat;
  } vec_t;

  // latency model: request phase ends one edge after the slowest ready, response one edge after it appears
  function automatic logic [15:0] lat_of(input vec_t v);
    longint l;
    if (v.write) l = longint'((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + 1 + v.b_dly + 1;
    else         l = longint'(v.ar_dly) + 1 + v.r_dly + 1;
    return (l > 65535) ? 16'hFFFF : l[15:0];
  endfunction

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int awd, input int wd, input int bd,
                              input int ard, input int rd, input logic [1:0] resp,
                              input logic [31:0] rdata, input int hold);
    vec_t v;
    v.write = wr; v.addr = addr; v.wdata = wdata; v.wstrb = strb;
    v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
    v.resp = resp; v.rdata = rdata; v.hold = hold;
    v.exp_lat = lat_of(v);
    return v;
  endfunction

  // driver: issue one command, push its expectation, then drain and compare the response
  task automatic run_vec(input vec_t v);
    logic [EXP_W-1:0] exp;
    logic [EXP_W-1:0] got;
    int aw0, w0, ar0;
    bit ok;
    cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly;
    cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly; cfg_resp = v.resp; cfg_rdata = v.rdata;
    @(negedge clk);
    aw0 = aw_beats; w0 = w_beats; ar0 = ar_beats;
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    exp_q.push_back({v.write, v.resp, (v.write ? 32'h0 : v.rdata), v.exp_lat});
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("cmd_accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom_range(0, 15));
    cmd_write = 1'($urandom_range(0, 1));
    for (int t = 0; t < 80000 && !rsp_valid; t++) @(negedge clk);
    if (!rsp_valid) begin
      check("rsp_timeout", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    got = {rsp_write, rsp_resp, rsp_rdata, rsp_latency};
    check("cmd_ready_during_rsp", cmd_ready, 0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("rsp_stable", {rsp_valid, rsp_write, rsp_resp, rsp_rdata, rsp_latency}, {1'b1, got});
      check("cmd_ready_blocked", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    exp = exp_q.pop_front();
    check("rsp_write", rsp_write, exp[50]);
    check("rsp_resp", rsp_resp, exp[49:48]);
    check("rsp_rdata", rsp_rdata, exp[47:16]);
    check("rsp_latency", rsp_latency, exp[15:0]);
    check("aw_beats", aw_beats - aw0, v.write ? 1 : 0);
    check("w_beats", w_beats - w0, v.write ? 1 : 0);
    check("ar_beats", ar_beats - ar0, v.write ? 0 : 1);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_clear", rsp_valid, 0);
    check("cmd_ready_after_rsp", cmd_ready, 1);
  endtask

  vec_t vecs[$];

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;

    vecs.push_back(mk(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0));
    vecs.push_back(mk(0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 3, 0, 2'b00, 32'h12345678, 0));
    vecs.push_back(mk(1, 32'h10, 32'hCAFEF00D, 4'h3, 4, 0, 0, 0, 0, 2'b00, 32'h0, 1));
    vecs.push_back(mk(1, 32'h14, 32'h0BADF00D, 4'hC, 0, 4, 0, 0, 0, 2'b00, 32'h0, 0));
    vecs.push_back(mk(0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 32'hA5A50001, 5));
    vecs.push_back(mk(1, 32'h24, 32'h11112222, 4'h1, 1, 2, 2, 0, 0, 2'b11, 32'h0, 2));
    vecs.push_back(mk(0, 32'h28, 32'h0, 4'h0, 0, 0, 0, 1, 3, 2'b11, 32'hFFFFFFFF, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                        $urandom, $urandom_range(0, 2)));

    // reset values
    repeat (2) @(negedge clk);
    check("rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_latency}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_axi_valid_ready", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
    check("rst_axi_addr_data", {axi.awaddr, axi.wdata}, 0);
    check("rst_axi_araddr_strb", {axi.araddr, axi.wstrb}, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset while the write request phase is stalled
    cfg_aw_dly = 20; cfg_w_dly = 20;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wr_req_entered", {axi.awvalid, axi.wvalid}, 2'b11);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_async_valids", {axi.awvalid, axi.wvalid, rsp_valid}, 0);
    check("rst_async_state", state_dbg, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1 check("cmd_ready_first_cycle", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_rsp_after_abandon", rsp_valid, 0);
    end
    run_vec(mk(1, 32'h44, 32'h13579BDF, 4'h5, 1, 0, 1, 0, 0, 2'b00, 32'h0, 0));

    // latency saturation
    run_vec(mk(1, 32'h48, 32'h2468ACE0, 4'hF, 0, 0, 70000, 0, 0, 2'b00, 32'h0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
